// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register carrying an
// instruction word and its PC+4 between two pipeline stages.
// SKID=1 adds a second entry so in_ready is purely register-derived;
// SKID=0 is a single register whose in_ready follows out_ready.
// A flush empties the stage and leaves a NOP bubble tagged with the
// incoming PC+4. A saturating counter records downstream stall cycles.
module pipe_stage_reg #(
   parameter int                INSN_W  = 32,
   parameter int                PC_W    = 32,
   parameter logic [INSN_W-1:0] NOP_VAL = '0,
   parameter int                SKID    = 1,
   parameter int                CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INSN_W-1:0] in_insn,
   input  logic [PC_W-1:0]   in_pc4,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INSN_W-1:0] out_insn,
   output logic [PC_W-1:0]   out_pc4,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Main entry: drives the outputs directly, so they are registered.
   logic              m_valid;
   logic [INSN_W-1:0] m_insn;
   logic [PC_W-1:0]   m_pc4;

   logic in_fire;
   logic out_fire;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = m_valid & out_ready;
   assign out_valid = m_valid;
   assign out_insn  = m_insn;
   assign out_pc4   = m_pc4;

   if (SKID != 0) begin : g_skid
      // Skid entry: catches the one entry accepted while main is stalled.
      logic              s_valid;
      logic [INSN_W-1:0] s_insn;
      logic [PC_W-1:0]   s_pc4;

      // Accept whenever the skid slot is free; independent of out_ready.
      assign in_ready = !s_valid;

      // Main/skid update: skid drains into main first to keep FIFO order.
      always_ff @(posedge clk) begin
         // NOTE: state uses non-blocking assignments so every register
         // samples pre-edge values; blocking here would chain skid->main
         // within one edge and break ordering.
         if (rst) begin
            m_valid <= 1'b0;
            m_insn  <= NOP_VAL;
            m_pc4   <= '0;
            s_valid <= 1'b0;
            s_insn  <= NOP_VAL;
            s_pc4   <= '0;
         end else if (flush) begin
            // Drop both held entries and anything arriving this cycle.
            m_valid <= 1'b0;
            m_insn  <= NOP_VAL;
            m_pc4   <= in_pc4;
            s_valid <= 1'b0;
         end else if (!m_valid || out_fire) begin
            if (s_valid) begin
               m_valid <= 1'b1;
               m_insn  <= s_insn;
               m_pc4   <= s_pc4;
               s_valid <= in_fire;
               if (in_fire) begin
                  s_insn <= in_insn;
                  s_pc4  <= in_pc4;
               end
            end else if (in_fire) begin
               m_valid <= 1'b1;
               m_insn  <= in_insn;
               m_pc4   <= in_pc4;
            end else begin
               // Bubble: payload keeps its last value, only valid drops.
               m_valid <= 1'b0;
            end
         end else if (in_fire) begin
            s_valid <= 1'b1;
            s_insn  <= in_insn;
            s_pc4   <= in_pc4;
         end
      end
   end else begin : g_noskid
      // Single register: room exists if empty or the entry leaves now.
      assign in_ready = !m_valid | out_ready;

      // Main update: reload from upstream whenever the slot frees up.
      always_ff @(posedge clk) begin
         if (rst) begin
            m_valid <= 1'b0;
            m_insn  <= NOP_VAL;
            m_pc4   <= '0;
         end else if (flush) begin
            m_valid <= 1'b0;
            m_insn  <= NOP_VAL;
            m_pc4   <= in_pc4;
         end else if (!m_valid || out_fire) begin
            m_valid <= in_valid;
            if (in_valid) begin
               m_insn <= in_insn;
               m_pc4  <= in_pc4;
            end
         end
      end
   end

   // Stall counter: valid entry refused downstream, saturating, rst-only clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (m_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
